// File: rtl/fetch_pkg.sv
// Shared types and default constants for the fetch/run-control stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int PC_W_DEF      = 10;
    localparam int LUT_W_DEF     = 4;
    localparam int LUT_DEPTH_DEF = 1 << LUT_W_DEF;

    // Absolute branch targets: entry i = 16*i. Regenerated by the assembler.
    localparam logic [PC_W_DEF-1:0] BR_TARGETS [LUT_DEPTH_DEF] = '{
        10'd0,   10'd16,  10'd32,  10'd48,  10'd64,  10'd80,  10'd96,  10'd112,
        10'd128, 10'd144, 10'd160, 10'd176, 10'd192, 10'd208, 10'd224, 10'd240
    };

    function automatic logic [31:0] br_target_default(input logic [31:0] idx);
        return idx << 4;
    endfunction

endpackage

// File: rtl/fetch_ctrl_branch_lut.sv
// Combinational branch-target ROM indexed by br_idx.
module branch_lut
    import fetch_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int LUT_W = LUT_W_DEF
) (
    input  logic [LUT_W-1:0] br_idx,
    output logic [PC_W-1:0]  target
);

    generate
        if (PC_W == PC_W_DEF && LUT_W == LUT_W_DEF) begin : g_table
            assign target = BR_TARGETS[br_idx];
        end else begin : g_formula
            // Non-default geometry falls back to the same 16*i rule, truncated.
            assign target = PC_W'(br_target_default(32'(br_idx)));
        end
    endgenerate

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter and IDLE/RUN/DONE run control with branch-LUT redirect,
// saturating RUN-cycle counter and sticky PC wrap flag.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          PC_W     = PC_W_DEF,
    parameter int          LUT_W    = LUT_W_DEF,
    parameter int          CNT_W    = 16,
    parameter int unsigned START_PC = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             stall,
    input  logic             halt,
    input  logic             br_taken,
    input  logic [LUT_W-1:0] br_idx,
    output logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             done,
    output logic             pc_wrap,
    output logic [CNT_W-1:0] cycles
);

    localparam logic [PC_W-1:0] START = PC_W'(START_PC);

    state_t             state, state_nx;
    logic [PC_W-1:0]    pc_nx, br_target;
    logic [CNT_W-1:0]   cycles_nx;
    logic               wrap_nx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    branch_lut #(.PC_W(PC_W), .LUT_W(LUT_W)) u_lut (
        .br_idx (br_idx),
        .target (br_target)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pc      <= START;
            cycles  <= '0;
            pc_wrap <= 1'b0;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            cycles  <= cycles_nx;
            pc_wrap <= wrap_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        cycles_nx = cycles;
        wrap_nx   = pc_wrap;
        case (state)
            RUN: begin
                if (req) begin
                    pc_nx     = START;
                    cycles_nx = '0;
                    wrap_nx   = 1'b0;
                end else begin
                    // Every non-restart RUN edge counts, stalled or halting.
                    cycles_nx = sat_inc(cycles);
                    if (!stall) begin
                        if (halt) begin
                            state_nx = DONE;
                        end else if (br_taken) begin
                            pc_nx = br_target;
                        end else begin
                            pc_nx = pc + PC_W'(1);
                            if (&pc) wrap_nx = 1'b1;
                        end
                    end
                end
            end
            default: begin
                // IDLE and DONE both restart on req and otherwise hold.
                if (req) begin
                    state_nx  = RUN;
                    pc_nx     = START;
                    cycles_nx = '0;
                    wrap_nx   = 1'b0;
                end
            end
        endcase
    end

    assign running = (state == RUN);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: driver updates a behavioural model and queues
// expected outputs; an independent monitor compares them after each edge.
module tb_fetch_ctrl;

    localparam int PC_W  = 10;
    localparam int LUT_W = 4;
    localparam int CNT_W = 8;
    localparam int PC_MOD  = 1 << PC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             req = 1'b0, stall = 1'b0, halt = 1'b0, br_taken = 1'b0;
    logic [LUT_W-1:0] br_idx = '0;
    logic [PC_W-1:0]  pc;
    logic             running, done, pc_wrap;
    logic [CNT_W-1:0] cycles;

    fetch_ctrl #(.PC_W(PC_W), .LUT_W(LUT_W), .CNT_W(CNT_W), .START_PC(0)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .stall    (stall),
        .halt     (halt),
        .br_taken (br_taken),
        .br_idx   (br_idx),
        .pc       (pc),
        .running  (running),
        .done     (done),
        .pc_wrap  (pc_wrap),
        .cycles   (cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PC_W-1:0]  pc;
        logic             running;
        logic             done;
        logic             wrap;
        logic [CNT_W-1:0] cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: plain integers and flags.
    int m_pc = 0, m_cyc = 0;
    bit m_run = 0, m_done = 0, m_wrap = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_cyc = 0; m_run = 0; m_done = 0; m_wrap = 0;
    endtask

    task automatic model_step(input bit r, input bit s, input bit h, input bit b, input int ix);
        if (!m_run) begin
            if (r) begin
                m_run = 1; m_done = 0; m_pc = 0; m_cyc = 0; m_wrap = 0;
            end
        end else if (r) begin
            m_pc = 0; m_cyc = 0; m_wrap = 0;
        end else begin
            m_cyc = (m_cyc < CNT_MAX) ? m_cyc + 1 : CNT_MAX;
            if (s) begin
                // held
            end else if (h) begin
                m_run = 0; m_done = 1;
            end else if (b) begin
                m_pc = (16 * ix) % PC_MOD;
            end else begin
                if (m_pc == PC_MOD - 1) m_wrap = 1;
                m_pc = (m_pc + 1) % PC_MOD;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit h, input bit b, input int ix);
        exp_t e;
        @(negedge clk);
        req = r; stall = s; halt = h; br_taken = b; br_idx = LUT_W'(ix);
        @(posedge clk);
        model_step(r, s, h, b, ix);
        e.pc = PC_W'(m_pc); e.running = m_run; e.done = m_done;
        e.wrap = m_wrap; e.cyc = CNT_W'(m_cyc);
        q.push_back(e);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        @(negedge clk);
        req = 0; stall = 0; halt = 0; br_taken = 0;
        #1 reset = 1'b0;
        #1;
        check("rst_pc", 32'(pc), 0);
        check("rst_running", 32'(running), 0);
        check("rst_done", 32'(done), 0);
        check("rst_wrap", 32'(pc_wrap), 0);
        check("rst_cycles", 32'(cycles), 0);
        model_reset();
        #1 reset = 1'b1;
    endtask

    // Monitor: one expected entry per driven edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("pc", 32'(pc), 32'(e.pc));
                check("running", 32'(running), 32'(e.running));
                check("done", 32'(done), 32'(e.done));
                check("pc_wrap", 32'(pc_wrap), 32'(e.wrap));
                check("cycles", 32'(cycles), 32'(e.cyc));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, s, h, b;
        model_reset();
        #3;
        check("init_pc", 32'(pc), 0);
        check("init_running", 32'(running), 0);
        check("init_done", 32'(done), 0);
        check("init_cycles", 32'(cycles), 0);
        @(negedge clk) reset = 1'b1;

        // IDLE ignores everything but req
        cyc(0, 1, 1, 1, 3);
        // Start and run
        cyc(1, 0, 0, 0, 0);
        idle_cycles(5);
        // Halt at pc=3, then hold halt while in DONE
        cyc(1, 0, 0, 0, 0);
        idle_cycles(3);
        for (int i = 0; i < 11; i++) cyc(0, 0, 1, 0, 0);
        // Branch, then branch+halt together
        cyc(1, 0, 0, 0, 0);
        idle_cycles(2);
        cyc(0, 0, 0, 1, 5);
        idle_cycles(1);
        cyc(0, 0, 1, 1, 7);
        idle_cycles(2);
        // Stall with halt pending
        cyc(1, 0, 0, 0, 0);
        idle_cycles(4);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        idle_cycles(2);
        // req held high keeps restarting
        cyc(1, 0, 0, 0, 0);
        idle_cycles(3);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 9);
        // Reset mid-RUN, then restart
        idle_cycles(3);
        async_reset();
        idle_cycles(2);
        cyc(1, 0, 0, 0, 0);
        idle_cycles(3);
        cyc(0, 0, 1, 0, 0);
        // req while in DONE
        cyc(1, 0, 0, 0, 0);
        idle_cycles(2);
        // Free-run through the PC wrap; counter saturates on the way
        cyc(1, 0, 0, 0, 0);
        idle_cycles(1030);
        // Reset mid-DONE
        cyc(0, 0, 1, 0, 0);
        idle_cycles(1);
        async_reset();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 15) == 0);
            s = ($urandom_range(0, 3) == 0);
            h = ($urandom_range(0, 11) == 0);
            b = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 299) == 0) async_reset();
            else cyc(r, s, h, b, $urandom_range(0, 15));
        end

        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Program-counter and run-control stage for the CSE141L core. It sits upstream of instruction memory and decode: it accepts the `req` start pulse and generates the program counter each cycle. It resolves taken branches through a small absolute-target lookup table, and raises `done` when decode reports a halt. `top_level` wires it between the bench handshake and the datapath.

## Interface
- `PC_W`, 10, program-counter width; instruction memory depth is 2^PC_W.
- `LUT_W`, 4, branch-target index width; the LUT holds 2^LUT_W entries.
- `CNT_W`, 16, width of the cycle counter.
- `START_PC`, 0, PC loaded on every start.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low. Low forces the reset state immediately, independent of `clk`.
- `req` input 1: start pulse from the bench; sampled each rising edge.
- `stall` input 1: freeze request from the datapath (multi-cycle op).
- `halt` input 1: decode has seen the halt instruction at the current `pc`.
- `br_taken` input 1: the current instruction is a branch whose condition is true.
- `br_idx` input LUT_W: index into the branch-target LUT.
- `pc` output PC_W: instruction-memory address.
- `running` output 1: high while the block is in RUN.
- `done` output 1: completion acknowledge.
- `pc_wrap` output 1: sticky flag, set when the PC incremented past 2^PC_W−1.
- `cycles` output CNT_W: count of RUN cycles since the last start.

## Operation
- The state machine has three states: IDLE, RUN, DONE.
- Reset values: state IDLE, `pc`=START_PC, `running`=0, `done`=0, `pc_wrap`=0, `cycles`=0.
- IDLE
  - With `req`=1: go to RUN. Load `pc`←START_PC, clear `cycles` and `pc_wrap`.
  - All other inputs are ignored.
- RUN: per-edge actions in priority order; the first matching one applies.
  1. `req`=1: restart. `pc`←START_PC, clear `cycles` and `pc_wrap`, stay in RUN.
  2. `stall`=1: `pc` holds. `cycles` still increments. `halt` and `br_taken` are ignored.
  3. `halt`=1: go to DONE with `pc` unchanged.
  4. `br_taken`=1: `pc`←lut[`br_idx`].
  5. Otherwise: `pc`←`pc`+1, modulo 2^PC_W. On the step from all-ones to 0, set `pc_wrap`.
- `cycles` increments on every RUN edge, including stall edges and the halting edge. It saturates at all-ones.
- DONE
  - `done`=1 and `running`=0. `pc` and `cycles` are frozen.
  - With `req`=1: behave as a start from IDLE (go to RUN, load START_PC, clear counters), and drop `done` on that edge.
  - Otherwise, stay in DONE indefinitely.
- Branch LUT
  - Synthesis-time constant table of PC_W-bit absolute targets, indexed combinationally by `br_idx`.
  - Default contents: entry i = 16·i.
- Reset asserted mid-RUN or mid-DONE aborts immediately to the reset values. The first edge after release behaves as IDLE.

## Timing
- All outputs are registered. `running` and `done` are decoded from the state register.
- Start latency: `req` sampled high at edge N gives `running`=1 and `pc`=START_PC after edge N.
- Halt latency: `halt` high at edge N gives `done`=1 after edge N. `pc` still shows the halt address.
- Branch: `br_taken` at edge N gives the target on `pc` after edge N. There is no delay slot.
- `halt` and `br_taken` together: halt wins, and `pc` does not move.
- `stall` together with `halt`: the halt is deferred until the first non-stall edge.
- `req` is a pulse. A `req` held high keeps restarting RUN every edge, so `pc` stays at START_PC.

## Structure
- Package `fetch_pkg` contains:
  - the state enum (IDLE, RUN, DONE);
  - default PC_W and LUT_W as localparams;
  - the default branch-target constant array.
- Sub-module `branch_lut` is a combinational ROM. Its input is `br_idx` and its output is the target. Keeping it separate lets the assembler regenerate its table.
- The top of `fetch_ctrl` holds the state register, the `pc` register, the cycle counter and the wrap flag.

## Test plan
- Start and run: pulse `req`, keep other inputs at 0 for 5 cycles.
  - Expect `pc` = 0,1,2,3,4 and `cycles`=5.
  - `done` stays 0 and `running` stays 1.
- Halt: start, hold `halt`=1 when `pc`=3.
  - Expect `done`=1 on the next cycle with `pc`=3.
  - Expect `cycles`=4, held constant for 10 further cycles.
- Branch and priority:
  - At `pc`=2 with `br_taken`=1 and `br_idx`=5: expect `pc`=80 next cycle, then 81.
  - At `pc`=81, assert `br_taken` and `halt` together: expect DONE with `pc`=81.
- Stall: at `pc`=4, hold `stall`=1 for 3 cycles while `halt`=1.
  - Expect `pc`=4 throughout and no `done` during the stall.
  - Expect `done`=1 one cycle after `stall` falls.
- Wrap: use START_PC=1020 with PC_W=10 and free-run.
  - Expect `pc` = 1021,1022,1023,0.
  - `pc_wrap` goes 1 on the step to 0 and stays 1.
- Reset and restart:
  - Drive `reset` low mid-RUN between clock edges: `pc`=0, `running`=0, `cycles`=0 immediately.
  - After release, a `req` restarts from 0.
  - A `req` while in DONE clears `done` and restarts at `pc`=0.
